nrd_ctrl: RTL and testbench

- Control sequencer for the 8-bit non-restoring divider datapath.
- Drives the one-hot control strobes that act on the A, Q and M registers: c0/c1/c2 load, c3 add/sub, c4 shift, c5 quotient bit, c6 correction, c7/c8 bus output.
- Consumes the sign bit s of register A and runs the full load, iterate, correct and unload sequence for one division per start pulse.

---
 rtl/nrd_pkg.sv | 35 +++
 rtl/nrd_iter_cnt.sv | 36 +++
 rtl/nrd_ctrl.sv | 124 ++++++++++++
 tb/tb_nrd_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/nrd_pkg.sv
// Shared definitions for the non-restoring divider control sequencer.
// Holds the default datapath width, the bit index of each control strobe
// inside the internal strobe vector, and the sequencer state encoding.
package nrd_pkg;

  localparam int unsigned N_DEF    = 8;
  localparam int unsigned CW_DEF   = 4;

  // Strobe-vector indices, one per control line c0..c8
  localparam int unsigned C0_IDX   = 0;  // load A from inbus
  localparam int unsigned C1_IDX   = 1;  // load Q from inbus
  localparam int unsigned C2_IDX   = 2;  // load M from inbus
  localparam int unsigned C3_IDX   = 3;  // A <= A +/- M
  localparam int unsigned C4_IDX   = 4;  // shift A:Q left
  localparam int unsigned C5_IDX   = 5;  // Q[0] <= ~s
  localparam int unsigned C6_IDX   = 6;  // correction A <= A + M
  localparam int unsigned C7_IDX   = 7;  // Q drives outbus
  localparam int unsigned C8_IDX   = 8;  // A drives outbus
  localparam int unsigned NUM_STRB = 9;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD_A  = 4'd1,
    LOAD_Q  = 4'd2,
    LOAD_M  = 4'd3,
    SHIFT   = 4'd4,
    ADDSUB  = 4'd5,
    SETQ    = 4'd6,
    CORRECT = 4'd7,
    OUT_Q   = 4'd8,
    OUT_A   = 4'd9,
    DONE    = 4'd10
  } state_t;

endpackage

// File: rtl/nrd_iter_cnt.sv
// Iteration counter for the divider sequencer.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   clr  : synchronous clear (start of a division)
//   inc  : advance by one (end of an iteration)
//   last : the incremented value equals N, i.e. this increment ends the
//          final iteration; the counter is cleared before reuse so it
//          never wraps
module nrd_iter_cnt #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt + CW'(1);
  assign last    = (cnt_inc == CW'(N));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/nrd_ctrl.sv
// Control sequencer for the N-bit non-restoring divider datapath.
// One start pulse in IDLE runs: load A/Q/M, N x (shift, add/sub, set
// quotient bit), optional remainder correction, unload Q then A, done.
//   clk, rst     : clock, asynchronous active-high reset
//   start        : launch a division (sampled in IDLE only)
//   s            : sign bit of register A
//   c0..c8       : one-hot control strobes (Moore-decoded)
//   sub          : adder direction with c3 (1 = A - M)
//   busy         : high from LOAD_A through OUT_A
//   done         : one-cycle pulse in DONE
module nrd_ctrl
  import nrd_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic s,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic c3,
  output logic c4,
  output logic c5,
  output logic c6,
  output logic c7,
  output logic c8,
  output logic sub,
  output logic busy,
  output logic done
);

  state_t              state;
  state_t              state_nxt;
  logic                op_sub;
  logic                cnt_clr;
  logic                cnt_inc;
  logic                cnt_last;
  logic [NUM_STRB-1:0] strb;

  nrd_iter_cnt #(
    .N  (N),
    .CW (CW)
  ) u_iter_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .last (cnt_last)
  );

  assign cnt_clr = (state == LOAD_M);
  assign cnt_inc = (state == SETQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Direction of the upcoming add/sub is set by the sign of A before the
  // shift: non-negative A subtracts M, negative A adds it back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_sub <= 1'b0;
    end else if (state == SHIFT) begin
      op_sub <= ~s;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = start ? LOAD_A : IDLE;
      LOAD_A:  state_nxt = LOAD_Q;
      LOAD_Q:  state_nxt = LOAD_M;
      LOAD_M:  state_nxt = SHIFT;
      SHIFT:   state_nxt = ADDSUB;
      ADDSUB:  state_nxt = SETQ;
      SETQ:    state_nxt = cnt_last ? CORRECT : SHIFT;
      CORRECT: state_nxt = OUT_Q;
      OUT_Q:   state_nxt = OUT_A;
      OUT_A:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    strb = '0;
    sub  = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      LOAD_A:  begin strb[C0_IDX] = 1'b1; busy = 1'b1; end
      LOAD_Q:  begin strb[C1_IDX] = 1'b1; busy = 1'b1; end
      LOAD_M:  begin strb[C2_IDX] = 1'b1; busy = 1'b1; end
      SHIFT:   begin strb[C4_IDX] = 1'b1; busy = 1'b1; end
      ADDSUB:  begin strb[C3_IDX] = 1'b1; sub = op_sub; busy = 1'b1; end
      SETQ:    begin strb[C5_IDX] = 1'b1; busy = 1'b1; end
      // correction only when the final remainder is negative
      CORRECT: begin strb[C6_IDX] = s;    busy = 1'b1; end
      OUT_Q:   begin strb[C7_IDX] = 1'b1; busy = 1'b1; end
      OUT_A:   begin strb[C8_IDX] = 1'b1; busy = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign c0 = strb[C0_IDX];
  assign c1 = strb[C1_IDX];
  assign c2 = strb[C2_IDX];
  assign c3 = strb[C3_IDX];
  assign c4 = strb[C4_IDX];
  assign c5 = strb[C5_IDX];
  assign c6 = strb[C6_IDX];
  assign c7 = strb[C7_IDX];
  assign c8 = strb[C8_IDX];

endmodule

// File: tb/tb_nrd_ctrl.sv
// Bench for nrd_ctrl: a register-level model of the A/Q/M datapath closes
// the loop on s; each division's expected cycle-by-cycle outputs come from
// the non-restoring algorithm run on plain arithmetic, and the unloaded
// quotient/remainder are compared with a/b and a%b.
module tb_nrd_ctrl;

  localparam int unsigned N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic s;
  logic c0, c1, c2, c3, c4, c5, c6, c7, c8, sub, busy, done;

  always #5 clk = ~clk;

  nrd_ctrl #(.N(N), .CW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .s(s),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6),
    .c7(c7), .c8(c8), .sub(sub), .busy(busy), .done(done)
  );

  // Datapath model driven by the strobes
  logic [N:0]   a_reg = '0;
  logic [N-1:0] q_reg = '0;
  logic [N-1:0] m_reg = '0;
  logic [N-1:0] dvd = '0;
  logic [N-1:0] dvs = '0;
  logic         s_zero = 1'b0;
  logic [N-1:0] outbus;
  logic [11:0]  obs_vec;

  assign s       = s_zero ? 1'b0 : a_reg[N];
  assign outbus  = c7 ? q_reg : (c8 ? a_reg[N-1:0] : '0);
  assign obs_vec = {done, busy, sub, c8, c7, c6, c5, c4, c3, c2, c1, c0};

  always @(posedge clk) begin
    if (c0) a_reg <= '0;
    if (c1) q_reg <= dvd;
    if (c2) m_reg <= dvs;
    if (c4) {a_reg, q_reg} <= {a_reg[N-1:0], q_reg, 1'b0};
    if (c3) a_reg <= sub ? a_reg - {1'b0, m_reg} : a_reg + {1'b0, m_reg};
    if (c5) q_reg[0] <= ~a_reg[N];
    if (c6) a_reg <= a_reg + {1'b0, m_reg};
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Non-restoring division on a 9-bit two's-complement partial remainder:
  // per iteration the add/sub direction, then whether correction is due.
  task automatic ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] subs, output logic fneg);
    logic [N:0] r;
    logic       sb;
    r = '0;
    for (int i = 0; i < int'(N); i++) begin
      sb      = ~r[N];
      subs[i] = sb;
      r       = {r[N-1:0], a[N-1-i]};
      r       = sb ? r - {1'b0, b} : r + {1'b0, b};
    end
    fneg = r[N];
  endtask

  // Expected {done,busy,sub,c8..c0} for cycle j after the start edge
  function automatic logic [11:0] exp_vec(input int j, input logic [N-1:0] subs,
                                          input logic fneg);
    logic [11:0] v;
    int          i;
    int          p;
    v = '0;
    if (j >= 1 && j <= 30) v[10] = 1'b1;
    if (j == 1) v[0] = 1'b1;
    if (j == 2) v[1] = 1'b1;
    if (j == 3) v[2] = 1'b1;
    if (j >= 4 && j <= 27) begin
      i = (j - 4) / 3;
      p = (j - 4) % 3;
      if (p == 0) v[4] = 1'b1;
      if (p == 1) begin v[3] = 1'b1; v[9] = subs[i]; end
      if (p == 2) v[5] = 1'b1;
    end
    if (j == 28) v[6] = fneg;
    if (j == 29) v[7] = 1'b1;
    if (j == 30) v[8] = 1'b1;
    if (j == 31) v[11] = 1'b1;
    return v;
  endfunction

  // Called at a negedge; asserts reset asynchronously and holds 3 cycles
  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    #1;
    chk("rst_async", 32'(obs_vec), 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold", 32'(obs_vec), 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release", 32'(obs_vec), 32'h0);
  endtask

  // mode 0: random start noise, 1: start held high, 2: extra start pulses
  // during iterations 2 and 7, 3: single clean pulse. Entered and left at
  // a negedge with the DUT in IDLE.
  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b,
                         input int mode, input bit szero, input int abort_at);
    logic [N-1:0] subs;
    logic         fneg;
    ref_div(a, b, subs, fneg);
    if (szero) begin
      subs = '1;
      fneg = 1'b0;
    end
    dvd    = a;
    dvs    = b;
    s_zero = szero;
    start  = 1'b1;
    @(posedge clk);
    for (int j = 1; j <= 31; j++) begin
      @(negedge clk);
      chk($sformatf("seq_%0d/%0d_c%0d", a, b, j), 32'(obs_vec), 32'(exp_vec(j, subs, fneg)));
      if (j == 29 && b != 0 && !szero) chk($sformatf("quot_%0d/%0d", a, b), 32'(outbus), 32'(a / b));
      if (j == 30 && b != 0 && !szero) chk($sformatf("rem_%0d/%0d", a, b), 32'(outbus), 32'(a % b));
      if (j == abort_at) begin
        do_reset();
        s_zero = 1'b0;
        return;
      end
      case (mode)
        0:       start = 1'($urandom_range(0, 1));
        1:       start = 1'b1;
        2:       start = (j == 7 || j == 22);
        default: start = 1'b0;
      endcase
      if (j == 31) start = (mode == 1);
    end
    @(negedge clk);
    chk("after_done_idle", 32'(obs_vec), 32'h0);
    s_zero = 1'b0;
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    int           md;
    int           ab;

    rst   = 1'b1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("pwrup_rst", 32'(obs_vec), 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("pwrup_release", 32'(obs_vec), 32'h0);

    run_div(8'd23, 8'd5, 3, 1'b1, 0);   // s forced 0: all subtract
    run_div(8'd23, 8'd5, 2, 1'b0, 0);   // start pulses mid-run ignored
    run_div(8'd7,  8'd3, 2, 1'b0, 0);   // correction path
    run_div(8'd200, 8'd7, 0, 1'b0, 12); // reset mid-run
    run_div(8'd23, 8'd5, 3, 1'b0, 0);
    run_div(8'd100, 8'd9, 1, 1'b0, 0);  // start held through DONE
    run_div(8'd55, 8'd6, 3, 1'b0, 0);
    run_div(8'd77, 8'd0, 3, 1'b0, 0);   // divide by zero still completes
    run_div(8'd255, 8'd255, 3, 1'b0, 0);
    run_div(8'd0, 8'd1, 3, 1'b0, 0);

    for (int k = 0; k < 24; k++) begin
      ra = N'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? N'(0) : N'($urandom);
      md = int'($urandom_range(0, 2));
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 30)) : 0;
      run_div(ra, rb, md, 1'b0, ab);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
